div_sequencer: RTL and testbench

- Multi-cycle sequencer for the RV32IM divide group: DIV, DIVU, REM and REMU.
- Sits beside the execute stage of the pipelined core.
  - Accepts one operation per start pulse.
  - Holds the pipeline stall (busy) while it iterates.
  - Returns a 32-bit result with a one-cycle done pulse.
- Owns the shared shift/subtract datapath and its control FSM.
- Handles RISC-V special cases without iterating.

---
 rtl/rv32m_pkg.sv | 32 +++
 rtl/div_datapath.sv | 32 +++
 rtl/div_sequencer.sv | 126 ++++++++++++
 tb/tb_div_sequencer.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/rv32m_pkg.sv
// Shared definitions for the RV32M divide sequencer: op encodings,
// FSM state constants and small arithmetic helpers.
package rv32m_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] DIV_OVF_A = 32'h8000_0000;

    // Values are the funct3 encodings, so funct3 can be compared directly.
    typedef enum logic [2:0] {
        DIV  = 3'b100,
        DIVU = 3'b101,
        REM  = 3'b110,
        REMU = 3'b111
    } div_op_e;

    typedef logic [2:0] div_state_e;

    localparam div_state_e ST_IDLE    = 3'd0;
    localparam div_state_e ST_SPECIAL = 3'd1;
    localparam div_state_e ST_SETUP   = 3'd2;
    localparam div_state_e ST_ITER    = 3'd3;
    localparam div_state_e ST_FIX     = 3'd4;

    function automatic logic op_is_signed(input logic [2:0] op);
        return (op == DIV) || (op == REM);
    endfunction

    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_datapath.sv
// One restoring-division step on {rem, quo} plus the final sign-fix negators.
// Purely combinational; all state lives in div_sequencer.
module div_datapath #(
    parameter int W = rv32m_pkg::XLEN
) (
    input  logic [W-1:0] rem,
    input  logic [W-1:0] quo,
    input  logic [W-1:0] divisor,
    input  logic         neg_q,
    input  logic         neg_r,
    output logic [W-1:0] rem_next,
    output logic [W-1:0] quo_next,
    output logic [W-1:0] quo_fixed,
    output logic [W-1:0] rem_fixed
);

    logic [W:0] rem_sh;
    logic [W:0] diff;
    logic       ge;

    // rem < divisor always holds, so rem_sh < 2*divisor and a W+1 bit
    // difference has its top bit set exactly when rem_sh < divisor.
    assign rem_sh = {rem, quo[W-1]};
    assign diff   = rem_sh - {1'b0, divisor};
    assign ge     = ~diff[W];

    assign rem_next  = ge ? diff[W-1:0] : rem_sh[W-1:0];
    assign quo_next  = {quo[W-2:0], ge};
    assign quo_fixed = neg_q ? (~quo + 1'b1) : quo;
    assign rem_fixed = neg_r ? (~rem + 1'b1) : rem;

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle DIV/DIVU/REM/REMU sequencer: control FSM and registers around
// the shared restoring-division datapath.
module div_sequencer #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    import rv32m_pkg::*;

    div_state_e      state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [2:0]       op_reg;
    logic [XLEN-1:0]  a_reg, b_reg;
    logic [XLEN-1:0]  rem_reg, quo_reg;
    logic             neg_q_reg, neg_r_reg;
    logic [XLEN-1:0]  result_reg;

    logic [XLEN-1:0]  rem_next, quo_next, quo_fixed, rem_fixed;
    logic [XLEN-1:0]  special_res, res_now;
    logic             start_ok, special_in, sgn_in, sgn_reg, is_rem;

    div_datapath #(.W(XLEN)) u_dp (
        .rem       (rem_reg),
        .quo       (quo_reg),
        .divisor   (b_reg),
        .neg_q     (neg_q_reg),
        .neg_r     (neg_r_reg),
        .rem_next  (rem_next),
        .quo_next  (quo_next),
        .quo_fixed (quo_fixed),
        .rem_fixed (rem_fixed)
    );

    assign sgn_in     = op_is_signed(funct3);
    assign start_ok   = start && funct3[2] && !flush;
    assign special_in = (op_b == '0) ||
                        (sgn_in && (op_a == DIV_OVF_A) && (op_b == '1));
    assign sgn_reg    = op_is_signed(op_reg);
    assign is_rem     = op_reg[1];

    // Only two special cases reach here: divide by zero and signed overflow.
    always_comb begin
        special_res = '0;
        if (b_reg == '0)
            special_res = is_rem ? a_reg : '1;
        else
            special_res = is_rem ? '0 : DIV_OVF_A;
    end

    always_comb begin
        res_now = result_reg;
        if (state_reg == ST_FIX)
            res_now = is_rem ? rem_fixed : quo_fixed;
        else if (state_reg == ST_SPECIAL)
            res_now = special_res;
    end

    assign busy   = (state_reg != ST_IDLE);
    assign done   = (state_reg == ST_FIX) || (state_reg == ST_SPECIAL);
    assign result = res_now;

    // A flush in a done state does not suppress done; both go to IDLE anyway.
    always_comb begin
        state_next = ST_IDLE;
        case (state_reg)
            ST_IDLE:    if (start_ok) state_next = special_in ? ST_SPECIAL : ST_SETUP;
            ST_SETUP:   state_next = flush ? ST_IDLE : ST_ITER;
            ST_ITER:    state_next = flush ? ST_IDLE :
                                     ((cnt_reg == '0) ? ST_FIX : ST_ITER);
            default:    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            op_reg     <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            rem_reg    <= '0;
            quo_reg    <= '0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
            result_reg <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                ST_IDLE: begin
                    if (start_ok) begin
                        a_reg  <= op_a;
                        b_reg  <= op_b;
                        op_reg <= funct3;
                    end
                end
                ST_SETUP: begin
                    quo_reg   <= sgn_reg ? abs32(a_reg) : a_reg;
                    b_reg     <= sgn_reg ? abs32(b_reg) : b_reg;
                    rem_reg   <= '0;
                    neg_q_reg <= sgn_reg & (a_reg[XLEN-1] ^ b_reg[XLEN-1]);
                    neg_r_reg <= sgn_reg & a_reg[XLEN-1];
                    cnt_reg   <= CNT_W'(XLEN - 1);
                end
                ST_ITER: begin
                    rem_reg <= rem_next;
                    quo_reg <= quo_next;
                    if (cnt_reg != '0)
                        cnt_reg <= cnt_reg - 1'b1;
                end
                ST_FIX, ST_SPECIAL: result_reg <= res_now;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: directed cases plus random ops
// compared against a plain-arithmetic RISC-V divide model.
module tb_div_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        flush = 1'b0;
    logic        busy, done;
    logic [31:0] result;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_res;
    int          exp_lat;
    logic [31:0] prev_res;

    div_sequencer dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv)
        else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // RISC-V M-extension semantics, including divide-by-zero and overflow.
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
        logic sgn;
        sgn = (f == 3'b100) || (f == 3'b110);
        if (b == 0)
            return f[1] ? a : 32'hFFFF_FFFF;
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return f[1] ? 32'h0 : 32'h8000_0000;
        case (f)
            3'b100:  return 32'($signed(a) / $signed(b));
            3'b101:  return a / b;
            3'b110:  return 32'($signed(a) % $signed(b));
            default: return a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] f, input logic [31:0] a,
                                      input logic [31:0] b);
        return (b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // Drives a request for one edge, then scrambles operands to prove they were latched.
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        exp_res = model(f, a, b);
        exp_lat = is_special(f, a, b) ? 2 : 35;
        start = 1'b1; funct3 = f; op_a = a; op_b = b;
        @(posedge clk); #1;
        start = 1'b0;
        op_a = $urandom; op_b = $urandom;
    endtask

    // Waits for done and checks latency, busy span, result and post-done behaviour.
    task automatic finish(input string tag, input bit b2b, input logic [31:0] na,
                          input logic [31:0] nb);
        int edges = 1;
        int busy_cyc = 0;
        while (!done && edges < 100) begin
            busy_cyc += int'(busy);
            @(posedge clk); #1;
            edges++;
        end
        busy_cyc += int'(busy);
        check({tag, "_latency"}, 32'(edges + 1), 32'(exp_lat));
        check({tag, "_busy_cycles"}, 32'(busy_cyc), 32'(exp_lat - 1));
        check({tag, "_result"}, result, exp_res);
        $display("op %s a->result=%h expected=%h latency=%0d", tag, result, exp_res, edges + 1);
        if (b2b) begin
            start = 1'b1; funct3 = 3'b101; op_a = na; op_b = nb;
        end
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
        check({tag, "_idle_busy"}, {31'b0, busy}, 32'd0);
        check({tag, "_held"}, result, exp_res);
        prev_res = exp_res;
    endtask

    initial begin
        logic [2:0]  rf;
        logic [31:0] ra, rb;

        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        issue(3'b101, 32'd100, 32'd7);                     finish("divu_100_7", 1'b0, 0, 0);
        issue(3'b111, 32'd100, 32'd7);                     finish("remu_100_7", 1'b0, 0, 0);
        issue(3'b100, 32'hFFFF_FFEC, 32'd3);               finish("div_m20_3", 1'b0, 0, 0);
        issue(3'b110, 32'hFFFF_FFEC, 32'd3);               finish("rem_m20_3", 1'b0, 0, 0);
        issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF);       finish("div_ovf", 1'b0, 0, 0);
        issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF);       finish("rem_ovf", 1'b0, 0, 0);
        issue(3'b101, 32'd5, 32'd0);                       finish("divu_by0", 1'b0, 0, 0);
        issue(3'b110, 32'hFFFF_FFF0, 32'd0);               finish("rem_by0", 1'b0, 0, 0);
        issue(3'b100, 32'h8000_0000, 32'd2);               finish("div_min_2", 1'b0, 0, 0);

        // Start held in the done cycle is not accepted until the following IDLE cycle.
        issue(3'b111, 32'd12345, 32'd100);
        finish("b2b_first", 1'b1, 32'd999, 32'd9);
        issue(3'b101, 32'd999, 32'd9);                     finish("b2b_second", 1'b0, 0, 0);

        // Flush mid-iteration: no done, result unchanged, next start works.
        issue(3'b101, 32'd1000, 32'd10);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        check("flush_no_done_before", {31'b0, done}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_busy", {31'b0, busy}, 32'd0);
        check("flush_done", {31'b0, done}, 32'd0);
        check("flush_result", result, prev_res);
        issue(3'b101, 32'd1000, 32'd10);                   finish("after_flush", 1'b0, 0, 0);

        // Flush with start in IDLE, and an invalid funct3, are both ignored.
        start = 1'b1; funct3 = 3'b101; op_a = 32'd7; op_b = 32'd2; flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        check("flush_start_busy", {31'b0, busy}, 32'd0);
        start = 1'b1; funct3 = 3'b011;
        @(posedge clk); #1;
        start = 1'b0;
        check("bad_funct3_busy", {31'b0, busy}, 32'd0);
        check("bad_funct3_result", result, prev_res);

        // Flush during a done cycle does not cancel the committed result.
        issue(3'b111, 32'd77, 32'd0);
        flush = 1'b1;
        #1;
        check("flush_in_done_done", {31'b0, done}, 32'd1);
        check("flush_in_done_result", result, 32'd77);
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_in_done_held", result, 32'd77);
        check("flush_in_done_busy", {31'b0, busy}, 32'd0);

        // Asynchronous reset mid-iteration clears outputs immediately.
        issue(3'b101, 32'd1000, 32'd10);
        repeat (15) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_busy", {31'b0, busy}, 32'd0);
        check("async_rst_done", {31'b0, done}, 32'd0);
        check("async_rst_result", result, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        issue(3'b101, 32'hFFFF_FFFF, 32'd1);               finish("after_reset", 1'b0, 0, 0);

        for (int i = 0; i < 24; i++) begin
            rf = 3'(4 + $urandom_range(0, 3));
            ra = $urandom;
            case ($urandom_range(0, 4))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = $urandom_range(1, 20);
                3:       rb = -$urandom_range(1, 20);
                default: rb = $urandom;
            endcase
            if (i % 6 == 5) ra = 32'h8000_0000;
            issue(rf, ra, rb);
            finish($sformatf("rand%0d_f%0d", i, rf), 1'b0, 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
